// File: rtl/ram_uart_dumper_pkg.sv
// Shared definitions for the RAM-to-UART dump engine: FSM states and default sizing.
package ram_uart_dumper_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_ADDR_W       = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_REQ    = 3'd1,
        RD_WAIT   = 3'd2,
        START_BIT = 3'd3,
        DATA_BITS = 3'd4,
        STOP_BIT  = 3'd5,
        DONE      = 3'd6
    } dump_state_e;

endpackage

// File: rtl/ram_uart_dumper_if.sv
// Host/RAM/serial-side signal bundle of the dumper; slave is the dumper, master the host and RAM.
interface ram_uart_dumper_if #(
    parameter int ADDR_W = ram_uart_dumper_pkg::DEF_ADDR_W
) ();

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_r_en;
    logic [7:0]        ram_data;
    logic              tx;
    logic              busy;
    logic              done;

    modport slave (
        input  start, base_addr, length, ram_data,
        output ram_addr, ram_r_en, tx, busy, done
    );

    modport master (
        output start, base_addr, length, ram_data,
        input  ram_addr, ram_r_en, tx, busy, done
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = ram_uart_dumper_pkg::DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       bit_done,
    output logic [3:0] bit_cnt
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] baud_cnt;
    logic [8:0]  shreg;
    logic        active;

    // load/ready: a byte is taken on a rising edge where load && ready; ready stays low
    // from that edge until the stop bit has been held for its full period.
    assign ready    = !active;
    // bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit.
    assign bit_done = active && (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active   <= 1'b0;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (!active) begin
            if (load) begin
                active   <= 1'b1;
                shreg    <= {1'b1, data};
                tx       <= 1'b0;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                active  <= 1'b0;
                tx      <= 1'b1;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/ram_uart_dumper.sv
// Reads a byte region from data RAM and streams it out as 8N1 UART frames.
module ram_uart_dumper
    import ram_uart_dumper_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_uart_dumper_if.slave bus,
    output dump_state_e      dbg_state
);

    dump_state_e       state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;

    logic       ser_load;
    logic       ser_ready;
    logic       ser_bit_done;
    logic [3:0] ser_bit_cnt;

    assign idx_next  = idx + 1'b1;
    assign ser_load  = (state == RD_WAIT) && ser_ready;
    assign dbg_state = state;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ser_load),
        .data    (bus.ram_data),
        .ready   (ser_ready),
        .tx      (bus.tx),
        .bit_done(ser_bit_done),
        .bit_cnt (ser_bit_cnt)
    );

    // Outputs are registered alongside the state, so they are set on the transition into
    // the state that owns them; the address wraps naturally at ADDR_W bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            idx          <= '0;
            bus.ram_addr <= '0;
            bus.ram_r_en <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.ram_r_en <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base_q   <= bus.base_addr;
                        len_q    <= bus.length;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        if (bus.length == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state        <= RD_REQ;
                            bus.ram_r_en <= 1'b1;
                            bus.ram_addr <= bus.base_addr;
                        end
                    end
                end
                RD_REQ:  state <= RD_WAIT;
                RD_WAIT: state <= START_BIT;
                START_BIT: begin
                    if (ser_bit_done) state <= DATA_BITS;
                end
                DATA_BITS: begin
                    if (ser_bit_done && ser_bit_cnt == 4'd8) state <= STOP_BIT;
                end
                STOP_BIT: begin
                    if (ser_bit_done) begin
                        idx <= idx_next;
                        if (idx_next == len_q) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state        <= RD_REQ;
                            bus.ram_r_en <= 1'b1;
                            bus.ram_addr <= base_q + idx_next;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_uart_dumper.sv
// Bench for ram_uart_dumper: table vectors, hand sequences and random dumps vs a cycle-formula model.
module tb_ram_uart_dumper;
    import ram_uart_dumper_pkg::*;

    localparam int C  = 4;
    localparam int AW = 12;
    localparam int P  = 2 + 10 * C;

    logic        clk = 1'b0;
    logic        rst_n;
    dump_state_e dbg_state;

    ram_uart_dumper_if #(.ADDR_W(AW)) bus ();

    ram_uart_dumper #(.CLKS_PER_BIT(C), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous data RAM: data appears the cycle after the read strobe.
    logic [7:0] mem [0:4095];
    always @(posedge clk) if (bus.ram_r_en) bus.ram_data <= mem[bus.ram_addr];

    int total = 0;
    int bad   = 0;

    logic        tx_tr[$];
    logic        ren_tr[$];
    logic        busy_tr[$];
    logic        done_tr[$];
    logic [11:0] addr_tr[$];
    logic [7:0]  exp_q[$];

    typedef struct {
        string       name;
        logic [11:0] base;
        int          n;
        int          exp_done;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] addr_of(input logic [11:0] base, input int i);
        return 12'((int'(base) + i) % 4096);
    endfunction

    // Line level at cycle c after a start in cycle 0: each byte owns P cycles, two idle-high
    // cycles (read request and wait) followed by a 10-bit frame of C cycles per bit.
    function automatic logic exp_tx(input int c, input logic [11:0] base, input int n);
        int i, k, b;
        logic [7:0] d;
        if (c < 1) return 1'b1;
        i = (c - 1) / P;
        k = (c - 1) % P;
        if (i >= n || k < 2) return 1'b1;
        b = (k - 2) / C;
        d = mem[addr_of(base, i)];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    function automatic logic exp_ren(input int c, input int n);
        if (c < 1) return 1'b0;
        return ((c - 1) % P == 0) && ((c - 1) / P < n);
    endfunction

    task automatic sample();
        tx_tr.push_back(bus.tx);
        ren_tr.push_back(bus.ram_r_en);
        busy_tr.push_back(bus.busy);
        done_tr.push_back(bus.done);
        addr_tr.push_back(bus.ram_addr);
    endtask

    task automatic run_dump(input string name, input logic [11:0] base, input int n,
                            input int exp_done, input int restart_cyc, input int abort_cyc);
        int done_cyc, budget, tx_err, ren_err, busy_err, done_err, quiet_err, frame_err, nbytes, c, s;
        logic [7:0] d;
        budget = (n + 1) * P + 10;
        tx_tr.delete(); ren_tr.delete(); busy_tr.delete(); done_tr.delete(); addr_tr.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem[addr_of(base, i)]);

        @(negedge clk);
        sample();
        bus.base_addr = base;
        bus.length    = 12'(n);
        bus.start     = 1'b1;
        done_cyc = -1;
        for (int cy = 1; cy <= budget; cy++) begin
            @(negedge clk);
            sample();
            if (abort_cyc != 0 && cy == abort_cyc)
                check({name, " state before abort"}, 32'(dbg_state), 32'(DATA_BITS));
            if (abort_cyc != 0 && cy == abort_cyc + 1) break;
            if (bus.done) begin
                done_cyc = cy;
                break;
            end
            if (cy == 1) bus.start = 1'b0;
            if (restart_cyc != 0 && cy == restart_cyc) begin
                bus.start     = 1'b1;
                bus.base_addr = 12'h100;
                bus.length    = 12'd5;
            end
            if (restart_cyc != 0 && cy == restart_cyc + 1) bus.start = 1'b0;
            if (abort_cyc != 0 && cy == abort_cyc) rst_n = 1'b0;
        end
        bus.start = 1'b0;

        if (abort_cyc != 0) begin
            check({name, " tx after reset"}, 32'(bus.tx), 32'd1);
            check({name, " busy after reset"}, 32'(bus.busy), 32'd0);
            check({name, " done after reset"}, 32'(bus.done), 32'd0);
            check({name, " ren after reset"}, 32'(bus.ram_r_en), 32'd0);
            check({name, " state after reset"}, 32'(dbg_state), 32'(IDLE));
            rst_n = 1'b1;
            quiet_err = 0;
            for (int q = 0; q < 3 * P; q++) begin
                @(negedge clk);
                if (bus.done || bus.ram_r_en || bus.busy || !bus.tx) quiet_err++;
            end
            check({name, " quiet after abort"}, 32'(quiet_err), 32'd0);
            return;
        end

        check({name, " done cycle"}, 32'(done_cyc), 32'(exp_done));
        if (done_cyc < 0) return;

        tx_err = 0; ren_err = 0; busy_err = 0; done_err = 0;
        for (int k = 0; k <= done_cyc; k++) begin
            if (tx_tr[k] !== exp_tx(k, base, n)) tx_err++;
            if (ren_tr[k] !== exp_ren(k, n)) ren_err++;
            else if (ren_tr[k] && addr_tr[k] !== addr_of(base, (k - 1) / P)) ren_err++;
            if (busy_tr[k] !== (k >= 1)) busy_err++;
            if (done_tr[k] !== (k == done_cyc)) done_err++;
        end
        check({name, " tx waveform errs"}, 32'(tx_err), 32'd0);
        check({name, " read strobe errs"}, 32'(ren_err), 32'd0);
        check({name, " busy errs"}, 32'(busy_err), 32'd0);
        check({name, " done pulse errs"}, 32'(done_err), 32'd0);

        // Independent receiver: find falling edges and sample mid-bit.
        nbytes = 0; frame_err = 0; c = 1;
        while (c <= done_cyc) begin
            if (tx_tr[c] === 1'b0 && tx_tr[c-1] === 1'b1) begin
                s = c;
                if (s + 9 * C + C / 2 > done_cyc) begin
                    frame_err++;
                    break;
                end
                for (int b = 0; b < 8; b++) d[b] = tx_tr[s + C * (b + 1) + C / 2];
                if (tx_tr[s + C / 2] !== 1'b0 || tx_tr[s + 9 * C + C / 2] !== 1'b1) frame_err++;
                if (exp_q.size() == 0) frame_err++;
                else check($sformatf("%s byte%0d", name, nbytes), 32'(d), 32'(exp_q.pop_front()));
                nbytes++;
                c = s + 10 * C;
            end else begin
                c++;
            end
        end
        check({name, " byte count"}, 32'(nbytes), 32'(n));
        check({name, " framing errs"}, 32'(frame_err), 32'd0);

        quiet_err = 0;
        for (int q = 0; q < 20; q++) begin
            @(negedge clk);
            if (bus.done || bus.ram_r_en || bus.busy || !bus.tx) quiet_err++;
        end
        check({name, " quiet after done"}, 32'(quiet_err), 32'd0);
    endtask

    initial begin
        int n;
        logic [11:0] base;

        vecs[0] = '{"single", 12'h010, 1, 43};
        vecs[1] = '{"wrap",   12'hFFF, 2, 85};
        vecs[2] = '{"zero",   12'h123, 0, 1};
        vecs[3] = '{"three",  12'h200, 3, 127};

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h010] = 8'hA5;
        mem[12'h011] = 8'h5A;
        mem[12'hFFF] = 8'h3C;
        mem[12'h000] = 8'hC3;

        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        check("reset tx", 32'(bus.tx), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset ren", 32'(bus.ram_r_en), 32'd0);
        check("reset addr", 32'(bus.ram_addr), 32'd0);
        check("reset state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_dump(vecs[i].name, vecs[i].base, vecs[i].n, vecs[i].exp_done, 0, 0);

        // Wrap again with explicit address and inter-frame gap checks.
        run_dump("wrap2", 12'hFFF, 2, 85, 0, 0);
        if (addr_tr.size() > 45) begin
            check("wrap first addr", 32'(addr_tr[1]), 32'h0FFF);
            check("wrap second ren", 32'(ren_tr[43]), 32'd1);
            check("wrap second addr", 32'(addr_tr[43]), 32'h0000);
            check("wrap gap tx43", 32'(tx_tr[43]), 32'd1);
            check("wrap gap tx44", 32'(tx_tr[44]), 32'd1);
            check("wrap frame2 start", 32'(tx_tr[45]), 32'd0);
        end else begin
            check("wrap trace length", 32'(addr_tr.size()), 32'd86);
        end

        run_dump("start_while_busy", 12'h010, 2, 85, 10, 0);
        run_dump("abort", 12'h010, 1, 0, 0, 15);
        run_dump("after_abort", 12'h010, 1, 43, 0, 0);

        for (int r = 0; r < 6; r++) begin
            base = 12'($urandom_range(0, 4095));
            n    = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) mem[addr_of(base, i)] = 8'($urandom);
            run_dump($sformatf("rand%0d", r), base, n, 1 + n * P, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_uart_dumper.md
RAM_UART_DUMPER -- requirements
Module: ram_uart_dumper

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 2..65535.
REQ-002 Parameter ADDR_W, default 12: data-RAM address width.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to dump a RAM region; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first byte address, captured on an accepted start.
REQ-007 length  input  ADDR_W  number of bytes to send, captured on an accepted start.
REQ-008 ram_addr  output  ADDR_W  data-RAM read address.
REQ-009 ram_r_en  output  1  data-RAM read strobe, one cycle per byte.
REQ-010 ram_data  input  8  data-RAM read data, valid the cycle after ram_r_en.
REQ-011 tx  output  1  UART serial line: 8N1, LSB first, idle high.
REQ-012 busy  output  1  high from the accepted start until the done cycle, inclusive.
REQ-013 done  output  1  one-cycle pulse when the dump completes.

Function
REQ-014 The block shall implement states IDLE, RD_REQ, RD_WAIT, START_BIT, DATA_BITS, STOP_BIT, DONE.
REQ-015 In IDLE, start=1 shall capture base_addr and length, clear byte index idx, and go to DONE if length=0, else to RD_REQ.
REQ-016 RD_REQ shall last one cycle, with ram_r_en=1 and ram_addr=(base+idx) mod 2^ADDR_W.
REQ-017 RD_WAIT shall last one cycle; at its end the block shall load ram_data into the shift register.
REQ-018 START_BIT shall hold tx=0 for exactly CLKS_PER_BIT cycles.
REQ-019 DATA_BITS shall drive shift-register bits 0..7 in order, each for exactly CLKS_PER_BIT cycles.
REQ-020 STOP_BIT shall hold tx=1 for CLKS_PER_BIT cycles, then increment idx.
REQ-021 After STOP_BIT, the block shall go to DONE if idx=length, else to RD_REQ.
REQ-022 DONE shall last one cycle, with done=1 and busy=1, then return to IDLE.
REQ-023 tx shall be 1 in IDLE, RD_REQ, RD_WAIT and DONE; the gap between frames shall be 2 cycles of idle-high.
REQ-024 Latency:
 - start sampled in cycle 0 gives ram_r_en in cycle 1 and the first tx=0 in cycle 3.
 - The total dump for N≥1 bytes shall be 1 + N*(2+10*CLKS_PER_BIT) cycles from start to done, inclusive of the done cycle.
REQ-025 start asserted while busy=1 shall be ignored, and captured base/length shall not change mid-dump.
REQ-026 ram_addr shall wrap modulo 2^ADDR_W (0xFFF+1 -> 0x000), and no error shall be flagged.
REQ-027 The baud counter shall be ≥16 bits wide, and bit/byte counters shall not overflow for length up to 2^ADDR_W-1.
REQ-028 ram_r_en shall never be asserted outside RD_REQ, so the processor keeps RAM ownership while the block is idle.

Reset
REQ-029 With rst_n=0 at a clock edge, the next cycle shall be IDLE with tx=1, busy=0, done=0, ram_r_en=0, ram_addr=0, and all counters 0.
REQ-030 Reset asserted mid-frame shall abort the dump immediately, with no done pulse and no completion of the partial byte.

Structure
REQ-031 The state enumeration and the default CLKS_PER_BIT/ADDR_W values shall live in the shared processor package.
REQ-032 Serialization (baud counter, bit counter, shift register, tx) shall be a sub-module uart_tx_serializer with a load/ready handshake; the top holds the RAM-read FSM and byte index.

Verification (CLKS_PER_BIT=4)
REQ-033 Reset: hold rst_n=0 for 2 cycles -> tx=1, busy=0, done=0, ram_r_en=0.
REQ-034 Single byte: RAM[0x010]=0xA5, base=0x010, length=1, start pulse -> ram_r_en in cycle 1 with ram_addr=0x010; tx=0,1,0,1,0,0,1,0,1,1 for 4 cycles each from cycle 3; done in cycle 43.
REQ-035 Zero length: length=0, start pulse -> done=1 in cycle 1; ram_r_en never asserted; tx stays 1.
REQ-036 Wrap: base=0xFFF, length=2, RAM[0xFFF]=0x3C, RAM[0x000]=0xC3 -> reads at 0xFFF then 0x000; bytes 0x3C, 0xC3 received; 2 idle cycles between frames; done in cycle 85.
REQ-037 Start while busy: second start with base=0x100 mid-dump is ignored; the original bytes are sent and only one done pulse occurs.
REQ-038 Reset mid-frame: rst_n=0 during DATA_BITS of 0xA5 -> tx=1, busy=0 next cycle; no done; a subsequent start works normally.
